updn_cntr_param: RTL and testbench
==================================

Name: updn_cntr_param

Overview:
Parametrised successor to the team's fixed-width up/down counter. Adds:
- configurable width and runtime terminal value (modulus);
- programmable step size;
- three boundary modes: wrap, saturate, one-shot;
- synchronous load, boundary-event pulse and sticky overflow flag.

Serves as the general event and timeout counter for the next-generation datapath and its testbenches.

Parameters:
WIDTH, 8, counter and terminal-value width in bits
STEP_W, 4, width of the step-size input

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  reset, asynchronous, active-high (reset_n=1 clears all state)
ena  in  1  count enable
up_dn  in  1  direction, 1=up, 0=down
step  in  STEP_W  increment/decrement amount; 0 = hold
mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap)
max_val  in  WIDTH  terminal value; count range 0..max_val
load  in  1  synchronous load strobe
load_val  in  WIDTH  value loaded on load
clr_ovf  in  1  clears sticky ovf
cnt_out  out  WIDTH  current count (registered)
term_cnt  out  1  registered; 1 when cnt_out equals terminal for current direction
evt  out  1  registered one-cycle pulse on a boundary event
ovf  out  1  sticky boundary-event flag
done  out  1  one-shot completed (state DONE)

Behaviour:
- Reset (async, reset_n=1): cnt_out=0, term_cnt=0, evt=0, ovf=0, done=0, state=RUN.
- Priority per edge: reset > load > count > hold.
- Load:
  - cnt_out<=load_val, state<=RUN, evt<=0.
  - load_val>max_val is loaded as-is.
- Count occurs when ena=1, no load, state=RUN. Arithmetic is done in WIDTH+1 bits.
- Up:
  - s = cnt_out+step.
  - If s<=max_val: cnt_out<=s.
  - Otherwise, boundary event:
    - wrap: cnt_out<=s-(max_val+1); if step>max_val, clamp to max_val instead.
    - saturate: cnt_out<=max_val.
    - one-shot: cnt_out<=max_val, state<=DONE.
- Down:
  - If step<=cnt_out: cnt_out<=cnt_out-step.
  - Otherwise, boundary event:
    - wrap: cnt_out<=cnt_out-step+max_val+1; if step>max_val, clamp to 0.
    - saturate: cnt_out<=0.
    - one-shot: cnt_out<=0, state<=DONE.
- Boundary event handling:
  - evt=1 for the following cycle.
  - ovf<=1; set wins over a simultaneous clr_ovf. clr_ovf alone clears ovf.
  - Saturated counter still being pushed past its bound: evt fires on every such edge.
- Exactly reaching the bound (s==max_val, or result 0) is not an event.
- Current count above max_val while counting up (max_val lowered mid-run): treated as an event.
- term_cnt is registered each edge from the next count value and current up_dn:
  - 1 iff next==max_val (up) or next==0 (down);
  - updated on every non-reset edge, including hold edges.
- FSM states: RUN, DONE.
  - RUN->DONE only on a one-shot event.
  - DONE->RUN on load, or when mode!=one-shot is sampled.
  - In DONE, ena is ignored and cnt_out holds.
  - done = (state==DONE).
- step=0 with ena: count holds; no event; term_cnt still re-evaluated.
- Latency: every output reflects inputs sampled at the previous rising edge; no combinational input-to-output paths.

Decomposition:
- Shared package updn_pkg:
  - cntr_mode_t enum (MODE_WRAP, MODE_SAT, MODE_ONESHOT);
  - cntr_state_t enum (ST_RUN, ST_DONE);
  - mode encoding constants.
- One sub-module: updn_next_val, purely combinational.
  - Inputs: cnt, step, max_val, up_dn, mode.
  - Outputs: next count, event flag.
  - Reused by the bench's reference model.
- Top holds the registers and the FSM.

Test Plan:
1. Reset mid-count: wrap, max_val=9, count to 5, pulse reset_n=1 between edges -> cnt_out=0, ovf=0, evt=0, done=0 immediately (async); counting resumes from 0 after release.
2. Wrap up: max_val=9, step=1, ena=1 from 0 -> 0..9, then 0; term_cnt=1 while cnt_out=9; evt=1 exactly one cycle with cnt_out=0; ovf=1 and stays 1 until clr_ovf.
3. Multi-step wrap: load 8, max_val=9, step=3, up -> 8, 1, 4, 7, 0; evt only after 8->1 and 7->0; down from 1 with step 3 -> 8.
4. Saturate down: mode=01, load 2, step=3, up_dn=0 -> 2, 0, 0, 0; evt high every cycle after the first clamp; term_cnt=1 while at 0.
5. One-shot: mode=10, max_val=5, step=2, up from 0 -> 0, 2, 4, 5, done=1; ena held 4 more cycles, cnt_out stays 5; load 0 -> done=0, counting restarts.
6. Simultaneous events: load=1 with ena=1 -> load_val wins; clr_ovf on the same edge as a wrap -> ovf stays 1; clr_ovf alone next cycle -> ovf=0.

Source files
------------

// File: rtl/updn_cntr_param_pkg.sv
// Shared types and mode encodings for the parameterised up/down counter.
package updn_pkg;

    // Raw 2-bit encodings as they appear on the mode input.
    localparam logic [1:0] MODE_ENC_WRAP    = 2'b00;
    localparam logic [1:0] MODE_ENC_SAT     = 2'b01;
    localparam logic [1:0] MODE_ENC_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_ENC_RSVD    = 2'b11;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10
    } cntr_mode_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } cntr_state_t;

    // The reserved encoding falls back to wrap behaviour.
    function automatic cntr_mode_t decode_mode(input logic [1:0] enc);
        cntr_mode_t m;
        case (enc)
            MODE_ENC_SAT:     m = MODE_SAT;
            MODE_ENC_ONESHOT: m = MODE_ONESHOT;
            default:          m = MODE_WRAP;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/updn_cntr_param_if.sv
// Control/status bundle of the up/down counter; master drives, slave counts.
interface updn_cntr_param_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              ena;
    logic              up_dn;
    logic [STEP_W-1:0] step;
    logic [1:0]        mode;
    logic [WIDTH-1:0]  max_val;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic              clr_ovf;
    logic [WIDTH-1:0]  cnt_out;
    logic              term_cnt;
    logic              evt;
    logic              ovf;
    logic              done;

    modport master (
        output ena, up_dn, step, mode, max_val, load, load_val, clr_ovf,
        input  cnt_out, term_cnt, evt, ovf, done
    );

    modport slave (
        input  ena, up_dn, step, mode, max_val, load, load_val, clr_ovf,
        output cnt_out, term_cnt, evt, ovf, done
    );
endinterface

// File: rtl/updn_cntr_param_next_val.sv
// Combinational next-count arithmetic with boundary detection for one count step.
// Arithmetic runs in WIDTH+1 bits so overshoot past the top of the range is visible.
// STEP_W is expected to be no larger than WIDTH.
module updn_next_val
    import updn_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic [WIDTH-1:0]  i_cnt,
    input  logic [STEP_W-1:0] i_step,
    input  logic [WIDTH-1:0]  i_max_val,
    input  logic              i_up_dn,
    input  cntr_mode_t        i_mode,
    output logic [WIDTH-1:0]  o_next,
    output logic              o_evt
);

    logic [WIDTH:0]   w_cnt_x;
    logic [WIDTH:0]   w_step_x;
    logic [WIDTH:0]   w_max_x;
    logic [WIDTH:0]   w_max_p1;
    logic [WIDTH:0]   w_sum;
    logic             w_step_gt_max;
    logic [WIDTH-1:0] w_wrap_up;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_wrap_dn;

    assign w_cnt_x       = {1'b0, i_cnt};
    assign w_step_x      = {{(WIDTH + 1 - STEP_W){1'b0}}, i_step};
    assign w_max_x       = {1'b0, i_max_val};
    assign w_max_p1      = w_max_x + 1'b1;
    assign w_sum         = w_cnt_x + w_step_x;
    assign w_step_gt_max = (w_step_x > w_max_x);
    // Residues after folding the overshoot back into 0..max_val.
    assign w_wrap_up     = WIDTH'(w_sum - w_max_p1);
    assign w_diff        = WIDTH'(w_cnt_x - w_step_x);
    assign w_wrap_dn     = WIDTH'(w_cnt_x - w_step_x + w_max_p1);

    // Select the in-range result or the mode-specific boundary result.
    always_comb begin
        o_next = i_cnt;
        o_evt  = 1'b0;
        if (i_step == '0) begin
            o_next = i_cnt;
        end else if (i_up_dn) begin
            if (w_sum <= w_max_x) begin
                o_next = w_sum[WIDTH-1:0];
            end else begin
                o_evt = 1'b1;
                case (i_mode)
                    MODE_SAT, MODE_ONESHOT: o_next = i_max_val;
                    default:                o_next = w_step_gt_max ? i_max_val : w_wrap_up;
                endcase
            end
        end else begin
            if (w_step_x <= w_cnt_x) begin
                o_next = w_diff;
            end else begin
                o_evt = 1'b1;
                case (i_mode)
                    MODE_SAT, MODE_ONESHOT: o_next = '0;
                    default:                o_next = w_step_gt_max ? '0 : w_wrap_dn;
                endcase
            end
        end
    end

endmodule

// File: rtl/updn_cntr_param.sv
// Parameterised up/down event/timeout counter: wrap, saturate and one-shot modes,
// synchronous load, registered terminal-count, event pulse and sticky overflow.
module updn_cntr_param
    import updn_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    updn_cntr_param_if.slave  if_cnt
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_term;
    logic             r_evt;
    logic             r_ovf;
    cntr_state_t      r_state;

    cntr_mode_t       w_mode;
    logic [WIDTH-1:0] w_arith_next;
    logic             w_arith_evt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_evt_nxt;
    logic             w_ovf_nxt;
    logic             w_term_nxt;
    cntr_state_t      w_state_nxt;

    assign w_mode = decode_mode(if_cnt.mode);

    updn_next_val #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_next_val (
        .i_cnt     (r_cnt),
        .i_step    (if_cnt.step),
        .i_max_val (if_cnt.max_val),
        .i_up_dn   (if_cnt.up_dn),
        .i_mode    (w_mode),
        .o_next    (w_arith_next),
        .o_evt     (w_arith_evt)
    );

    // Next-state and next-output decode: load beats count beats hold; DONE freezes the count.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_evt_nxt   = 1'b0;
        w_state_nxt = r_state;
        if (if_cnt.load) begin
            w_cnt_nxt   = if_cnt.load_val;
            w_state_nxt = ST_RUN;
        end else if (r_state == ST_DONE) begin
            if (w_mode != MODE_ONESHOT) begin
                w_state_nxt = ST_RUN;
            end
        end else if (if_cnt.ena) begin
            w_cnt_nxt = w_arith_next;
            w_evt_nxt = w_arith_evt;
            if (w_arith_evt && (w_mode == MODE_ONESHOT)) begin
                w_state_nxt = ST_DONE;
            end
        end
        // A new event outranks a clear arriving on the same edge.
        w_ovf_nxt  = w_evt_nxt ? 1'b1 : (if_cnt.clr_ovf ? 1'b0 : r_ovf);
        w_term_nxt = if_cnt.up_dn ? (w_cnt_nxt == if_cnt.max_val) : (w_cnt_nxt == '0);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Count and status registers.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_cnt  <= '0;
            r_term <= 1'b0;
            r_evt  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_term <= w_term_nxt;
            r_evt  <= w_evt_nxt;
            r_ovf  <= w_ovf_nxt;
        end
    end

    assign if_cnt.cnt_out  = r_cnt;
    assign if_cnt.term_cnt = r_term;
    assign if_cnt.evt      = r_evt;
    assign if_cnt.ovf      = r_ovf;
    assign if_cnt.done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_updn_cntr_param.sv
// Scoreboard bench for updn_cntr_param: driver pushes reference-model expectations,
// monitor pops and compares one entry per rising edge.
module tb_updn_cntr_param;

    localparam int W  = 8;
    localparam int SW = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    updn_cntr_param_if #(.WIDTH(W), .STEP_W(SW)) bus ();

    updn_cntr_param #(.WIDTH(W), .STEP_W(SW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .if_cnt  (bus)
    );

    typedef struct {
        int cnt;
        bit term;
        bit evt;
        bit ovf;
        bit done;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_no  = 0;

    // Reference model state
    int m_cnt;
    bit m_term, m_evt, m_ovf, m_done;

    function automatic exp_t sample_dut();
        exp_t a;
        a.cnt  = int'(bus.cnt_out);
        a.term = bus.term_cnt;
        a.evt  = bus.evt;
        a.ovf  = bus.ovf;
        a.done = bus.done;
        return a;
    endfunction

    function automatic void check(string name, exp_t a, exp_t e);
        n_tests++;
        if (a.cnt != e.cnt || a.term != e.term || a.evt != e.evt ||
            a.ovf != e.ovf || a.done != e.done) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got cnt=%0d term=%0b evt=%0b ovf=%0b done=%0b want cnt=%0d term=%0b evt=%0b ovf=%0b done=%0b",
                     name, cyc_no, a.cnt, a.term, a.evt, a.ovf, a.done,
                     e.cnt, e.term, e.evt, e.ovf, e.done);
        end
    endfunction

    function automatic void model_reset();
        m_cnt = 0; m_term = 0; m_evt = 0; m_ovf = 0; m_done = 0;
    endfunction

    // Behavioural rules applied to one rising edge.
    function automatic void model_step(bit ld, int lv, bit en, bit up, int st, int md, int mx, bit clr);
        bit ev = 0;
        int s;
        int eff = (md == 3) ? 0 : md;
        if (ld) begin
            m_cnt  = lv;
            m_done = 0;
        end else if (m_done) begin
            if (eff != 2) m_done = 0;
        end else if (en && st != 0) begin
            if (up) begin
                s = m_cnt + st;
                if (s <= mx) m_cnt = s;
                else begin
                    ev = 1;
                    if (eff == 0) m_cnt = (st > mx) ? mx : s - (mx + 1);
                    else          m_cnt = mx;
                    if (eff == 2) m_done = 1;
                end
            end else begin
                if (st <= m_cnt) m_cnt = m_cnt - st;
                else begin
                    ev = 1;
                    if (eff == 0) m_cnt = (st > mx) ? 0 : m_cnt - st + mx + 1;
                    else          m_cnt = 0;
                    if (eff == 2) m_done = 1;
                end
            end
        end
        m_cnt  = m_cnt % (1 << W);
        m_evt  = ev;
        if (ev)       m_ovf = 1;
        else if (clr) m_ovf = 0;
        m_term = up ? (m_cnt == mx) : (m_cnt == 0);
    endfunction

    task automatic apply(input bit ld, input int lv, input bit en, input bit up,
                         input int st, input int md, input int mx, input bit clr);
        exp_t e;
        bus.load     = ld;
        bus.load_val = W'(lv);
        bus.ena      = en;
        bus.up_dn    = up;
        bus.step     = SW'(st);
        bus.mode     = 2'(md);
        bus.max_val  = W'(mx);
        bus.clr_ovf  = clr;
        model_step(ld, lv, en, up, st, md, mx, clr);
        e.cnt = m_cnt; e.term = m_term; e.evt = m_evt; e.ovf = m_ovf; e.done = m_done;
        sb_q.push_back(e);
    endtask

    task automatic drive(input bit ld, input int lv, input bit en, input bit up,
                         input int st, input int md, input int mx, input bit clr);
        @(negedge clk);
        apply(ld, lv, en, up, st, md, mx, clr);
    endtask

    // Asynchronous reset pulse between edges, checked immediately, then next stimulus.
    task automatic reset_then(input bit ld, input int lv, input bit en, input bit up,
                              input int st, input int md, input int mx, input bit clr);
        exp_t z;
        z.cnt = 0; z.term = 0; z.evt = 0; z.ovf = 0; z.done = 0;
        @(negedge clk);
        #1 reset_n = 1'b1;
        #1 check("async_reset", sample_dut(), z);
        #1 reset_n = 1'b0;
        model_reset();
        apply(ld, lv, en, up, st, md, mx, clr);
    endtask

    // Monitor: one expectation retired per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc_no++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("cycle", sample_dut(), e);
            end
        end
    end

    initial begin
        exp_t z;
        bus.load = 0; bus.load_val = '0; bus.ena = 0; bus.up_dn = 1;
        bus.step = '0; bus.mode = 2'b00; bus.max_val = '0; bus.clr_ovf = 0;
        model_reset();
        z.cnt = 0; z.term = 0; z.evt = 0; z.ovf = 0; z.done = 0;
        repeat (3) @(posedge clk);
        #1 check("reset_state", sample_dut(), z);
        @(negedge clk);
        reset_n = 1'b0;

        // Count to 5, async reset mid-cycle, resume from 0 and wrap past 9.
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 1, 1, 0, 9, 0);
        reset_then(0, 0, 1, 1, 1, 0, 9, 0);
        for (int i = 0; i < 13; i++) drive(0, 0, 1, 1, 1, 0, 9, 0);
        drive(0, 0, 0, 1, 1, 0, 9, 0);
        drive(0, 0, 0, 1, 1, 0, 9, 1);

        // Multi-step wrap up, then down across zero.
        drive(1, 8, 0, 1, 3, 0, 9, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 1, 3, 0, 9, 0);
        drive(1, 1, 0, 0, 3, 0, 9, 0);
        drive(0, 0, 1, 0, 3, 0, 9, 0);

        // Saturate down with repeated push past zero.
        drive(1, 2, 0, 0, 3, 1, 9, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 3, 1, 9, 0);

        // One-shot up to 5, hold in DONE, load restarts.
        drive(1, 0, 0, 1, 2, 2, 5, 1);
        for (int i = 0; i < 7; i++) drive(0, 0, 1, 1, 2, 2, 5, 0);
        drive(1, 0, 1, 1, 2, 2, 5, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 1, 2, 2, 5, 0);
        // Leave DONE by switching mode, then count in wrap.
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 2, 0, 5, 0);

        // Load beats count; clear loses to a simultaneous event; clear alone works.
        drive(1, 3, 1, 1, 1, 0, 9, 0);
        drive(1, 9, 0, 1, 1, 0, 9, 1);
        drive(0, 0, 1, 1, 1, 0, 9, 1);
        drive(0, 0, 0, 1, 1, 0, 9, 1);
        drive(0, 0, 1, 1, 0, 0, 9, 0);

        // Bound lowered below current count while counting up; oversized load; step > max.
        drive(1, 8, 0, 1, 1, 0, 9, 0);
        drive(0, 0, 1, 1, 1, 0, 5, 0);
        drive(1, 200, 0, 1, 1, 1, 20, 0);
        drive(0, 0, 1, 1, 1, 1, 20, 0);
        drive(1, 2, 0, 1, 1, 0, 4, 0);
        drive(0, 0, 1, 1, 7, 0, 4, 0);
        drive(0, 0, 1, 0, 7, 3, 4, 0);

        // Randomised traffic with small bounds to stress the boundaries.
        begin
            int mx = 9;
            for (int i = 0; i < 800; i++) begin
                bit ld  = ($urandom_range(0, 15) == 0);
                int lv  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, mx);
                bit en  = ($urandom_range(0, 3) != 0);
                bit up  = $urandom_range(0, 1);
                int st  = $urandom_range(0, 15);
                int md  = $urandom_range(0, 3);
                bit clr = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 31) == 0)
                    mx = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 20);
                if ($urandom_range(0, 99) == 0) reset_then(ld, lv, en, up, st, md, mx, clr);
                else                            drive(ld, lv, en, up, st, md, mx, clr);
            end
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending entries want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
